// File: rtl/multi_core_boot_sequencer_if.sv
// Core-facing bus of the boot sequencer: reset, start and program address out,
// completion flags back. The sequencer is the master, the core array the slave.
interface multi_core_boot_sequencer_if #(
  parameter int NUM_CORES    = 4,
  parameter int ADDRESS_BITS = 20
);
  logic [NUM_CORES-1:0]              core_reset;
  logic [NUM_CORES-1:0]              core_start;
  logic [NUM_CORES*ADDRESS_BITS-1:0] core_prog_address;
  logic [NUM_CORES-1:0]              core_done;

  modport master (
    output core_reset,
    output core_start,
    output core_prog_address,
    input  core_done
  );

  modport slave (
    input  core_reset,
    input  core_start,
    input  core_prog_address,
    output core_done
  );
endinterface

// File: rtl/multi_core_boot_sequencer.sv
// Holds an array of cores in reset, releases them together, issues staggered
// start pulses with per-core program addresses, then counts run cycles until all
// cores report done. Build with BOOT_TIMEOUT_EN to add the run-cycle watchdog.
module multi_core_boot_sequencer #(
  parameter int NUM_CORES      = 4,
  parameter int ADDRESS_BITS   = 20,
  parameter int PROG_STRIDE    = 'h1000,
  parameter int RESET_CYCLES   = 2,
  parameter int START_CYCLES   = 1,
  parameter int STAGGER        = 2,
  parameter int COUNT_BITS     = 32,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    go,
  input  logic [ADDRESS_BITS-1:0] prog_base,
  multi_core_boot_sequencer_if.master cores,
  output logic                    report,
  output logic                    busy,
  output logic                    boot_done,
  output logic [COUNT_BITS-1:0]   cycle_count,
  output logic                    timeout
);

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    START,
    GAP,
    RUN,
    DONE
  } state_t;

  localparam int IDX_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int PH_MAX = (RESET_CYCLES > START_CYCLES)
                          ? ((RESET_CYCLES > STAGGER) ? RESET_CYCLES : STAGGER)
                          : ((START_CYCLES > STAGGER) ? START_CYCLES : STAGGER);
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PH_W-1:0]       HOLD_LAST     = PH_W'(RESET_CYCLES - 1);
  localparam logic [PH_W-1:0]       START_LAST    = PH_W'(START_CYCLES - 1);
  localparam logic [PH_W-1:0]       GAP_LAST      = PH_W'((STAGGER > 0) ? STAGGER - 1 : 0);
  localparam logic [IDX_W-1:0]      LAST_IDX      = IDX_W'(NUM_CORES - 1);
  localparam logic [COUNT_BITS-1:0] TIMEOUT_LIMIT = COUNT_BITS'(TIMEOUT_CYCLES);

  state_t                 state;
  logic [PH_W-1:0]        phase_cnt;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_next;
  logic [NUM_CORES-1:0]   done_mask;
  logic [NUM_CORES-1:0]   mask_next;
  logic                   mask_full;
  logic [COUNT_BITS-1:0]  count_next;

  // NOTE: every signal written in always_comb gets a value on every path (here
  // unconditionally), otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    idx_next   = idx + IDX_W'(1);
    mask_next  = done_mask | cores.core_done;
    mask_full  = &mask_next;
    count_next = (cycle_count == '1) ? cycle_count : cycle_count + COUNT_BITS'(1);
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                   <= IDLE;
      phase_cnt               <= '0;
      idx                     <= '0;
      done_mask               <= '0;
      cores.core_reset        <= '1;
      cores.core_start        <= '0;
      cores.core_prog_address <= '0;
      report                  <= 1'b0;
      busy                    <= 1'b0;
      boot_done               <= 1'b0;
      cycle_count             <= '0;
`ifdef BOOT_TIMEOUT_EN
      timeout                 <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (go) begin
            for (int i = 0; i < NUM_CORES; i++) begin
              // Width-ADDRESS_BITS arithmetic wraps the address space naturally.
              cores.core_prog_address[i*ADDRESS_BITS +: ADDRESS_BITS] <=
                prog_base + ADDRESS_BITS'(i) * ADDRESS_BITS'(PROG_STRIDE);
            end
            cycle_count      <= '0;
            boot_done        <= 1'b0;
            done_mask        <= '0;
            busy             <= 1'b1;
            cores.core_reset <= '1;
            phase_cnt        <= '0;
            state            <= HOLD;
`ifdef BOOT_TIMEOUT_EN
            timeout          <= 1'b0;
`endif
          end
        end

        HOLD: begin
          if (phase_cnt == HOLD_LAST) begin
            cores.core_reset <= '0;
            cores.core_start <= NUM_CORES'(1);
            idx              <= '0;
            phase_cnt        <= '0;
            state            <= START;
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end

        START: begin
          if (phase_cnt == START_LAST) begin
            phase_cnt        <= '0;
            cores.core_start <= '0;
            if (idx == LAST_IDX) begin
              report <= 1'b1;
              state  <= RUN;
            end else if (STAGGER == 0) begin
              cores.core_start[idx_next] <= 1'b1;
              idx                        <= idx_next;
            end else begin
              state <= GAP;
            end
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end

        GAP: begin
          if (phase_cnt == GAP_LAST) begin
            cores.core_start[idx_next] <= 1'b1;
            idx                        <= idx_next;
            phase_cnt                  <= '0;
            state                      <= START;
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end

        RUN: begin
          done_mask <= mask_next;
          if (mask_full) begin
            cycle_count <= count_next;
            report      <= 1'b0;
            busy        <= 1'b0;
            boot_done   <= 1'b1;
            state       <= DONE;
`ifdef BOOT_TIMEOUT_EN
          end else if (cycle_count >= TIMEOUT_LIMIT) begin
            // Watchdog expiry freezes the count at the limit it reached.
            timeout     <= 1'b1;
            report      <= 1'b0;
            busy        <= 1'b0;
            boot_done   <= 1'b1;
            state       <= DONE;
`endif
          end else begin
            cycle_count <= count_next;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifndef BOOT_TIMEOUT_EN
  logic unused_timeout_limit;
  assign unused_timeout_limit = ^TIMEOUT_LIMIT;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_multi_core_boot_sequencer.sv
// Scoreboard bench: two sequencer instances (default stagger, and back-to-back
// 3-cycle pulses); expected start pulses and completions are queued when driven.
module tb_multi_core_boot_sequencer;

  localparam int NC = 4;
  localparam int AB = 20;
  localparam int CB = 32;
  localparam int TO = 50;

  typedef struct {
    int             core;
    int             cyc;
    logic [AB-1:0]  addr;
  } start_ev_t;

  typedef struct {
    int   count;
    logic to;
  } done_ev_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          go_a = 1'b0, go_b = 1'b0;
  logic [AB-1:0] base_a = '0, base_b = '0;
  logic          report_a, busy_a, boot_done_a, timeout_a;
  logic          report_b, busy_b, boot_done_b, timeout_b;
  logic [CB-1:0] count_a, count_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  start_ev_t sq_a[$], sq_b[$];
  done_ev_t  dq_a[$], dq_b[$];
  logic [NC-1:0] prev_st [2];
  logic          prev_rpt [2];
  logic          prev_done [2];
  int            rise_cyc [2][NC];
  int            exp_run [2];

  multi_core_boot_sequencer_if #(.NUM_CORES(NC), .ADDRESS_BITS(AB)) bus_a ();
  multi_core_boot_sequencer_if #(.NUM_CORES(NC), .ADDRESS_BITS(AB)) bus_b ();

  multi_core_boot_sequencer #(
    .NUM_CORES(NC), .ADDRESS_BITS(AB), .PROG_STRIDE('h1000), .RESET_CYCLES(2),
    .START_CYCLES(1), .STAGGER(2), .COUNT_BITS(CB), .TIMEOUT_CYCLES(TO)
  ) dut_a (
    .clock(clock), .reset(reset), .go(go_a), .prog_base(base_a), .cores(bus_a),
    .report(report_a), .busy(busy_a), .boot_done(boot_done_a),
    .cycle_count(count_a), .timeout(timeout_a)
  );

  multi_core_boot_sequencer #(
    .NUM_CORES(NC), .ADDRESS_BITS(AB), .PROG_STRIDE('h1000), .RESET_CYCLES(2),
    .START_CYCLES(3), .STAGGER(0), .COUNT_BITS(CB), .TIMEOUT_CYCLES(TO)
  ) dut_b (
    .clock(clock), .reset(reset), .go(go_b), .prog_base(base_b), .cores(bus_b),
    .report(report_b), .busy(busy_b), .boot_done(boot_done_b),
    .cycle_count(count_b), .timeout(timeout_b)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic observe(input int d);
    logic [NC-1:0]    st, cr;
    logic [NC*AB-1:0] ad;
    logic             bsy, bdn, rpt, to;
    logic [CB-1:0]    cnt;
    start_ev_t        e;
    done_ev_t         de;
    bit               have;
    int               width;
    if (d == 0) begin
      st = bus_a.core_start; cr = bus_a.core_reset; ad = bus_a.core_prog_address;
      bsy = busy_a; bdn = boot_done_a; rpt = report_a; to = timeout_a; cnt = count_a;
    end else begin
      st = bus_b.core_start; cr = bus_b.core_reset; ad = bus_b.core_prog_address;
      bsy = busy_b; bdn = boot_done_b; rpt = report_b; to = timeout_b; cnt = count_b;
    end
    width = (d == 0) ? 1 : 3;
    if (!reset) begin
      prev_st[d] = '0; prev_rpt[d] = 1'b0; prev_done[d] = 1'b0;
      return;
    end
    for (int i = 0; i < NC; i++) begin
      if (st[i] && !prev_st[d][i]) begin
        have = 1'b1;
        if (d == 0) begin
          if (sq_a.size() == 0) have = 1'b0; else e = sq_a.pop_front();
        end else begin
          if (sq_b.size() == 0) have = 1'b0; else e = sq_b.pop_front();
        end
        if (!have) begin
          check($sformatf("d%0d_unexpected_start%0d", d, i), 1, 0);
        end else begin
          check($sformatf("d%0d_start_core", d), i, e.core);
          check($sformatf("d%0d_start%0d_cycle", d, i), cyc, e.cyc);
          check($sformatf("d%0d_addr%0d", d, i), ad[i*AB +: AB], e.addr);
          check($sformatf("d%0d_reset_released%0d", d, i), cr, 0);
          check($sformatf("d%0d_busy_at_start%0d", d, i), bsy, 1);
        end
        rise_cyc[d][i] = cyc;
      end
      if (!st[i] && prev_st[d][i])
        check($sformatf("d%0d_pulse_width%0d", d, i), cyc - rise_cyc[d][i], width);
    end
    if (st != '0) check($sformatf("d%0d_start_onehot", d), $onehot(st), 1);
    if (rpt && !prev_rpt[d]) check($sformatf("d%0d_run_entry_cycle", d), cyc, exp_run[d]);
    if (bdn && !prev_done[d]) begin
      have = 1'b1;
      if (d == 0) begin
        if (dq_a.size() == 0) have = 1'b0; else de = dq_a.pop_front();
      end else begin
        if (dq_b.size() == 0) have = 1'b0; else de = dq_b.pop_front();
      end
      if (!have) begin
        check($sformatf("d%0d_unexpected_done", d), 1, 0);
      end else begin
        check($sformatf("d%0d_cycle_count", d), cnt, de.count);
        check($sformatf("d%0d_timeout", d), to, de.to);
        check($sformatf("d%0d_busy_at_done", d), bsy, 0);
        check($sformatf("d%0d_report_at_done", d), rpt, 0);
      end
    end
    prev_st[d] = st; prev_rpt[d] = rpt; prev_done[d] = bdn;
  endtask

  always @(negedge clock) begin
    observe(0);
    observe(1);
  end

  // Issue a one-cycle go and queue the start pulses the sequence must produce.
  task automatic boot(input int d, input logic [AB-1:0] base);
    int a, s, g;
    start_ev_t e;
    s = (d == 0) ? 1 : 3;
    g = (d == 0) ? 2 : 0;
    @(negedge clock);
    if (d == 0) begin go_a = 1'b1; base_a = base; end
    else        begin go_b = 1'b1; base_b = base; end
    a = cyc + 1;
    for (int i = 0; i < NC; i++) begin
      e.core = i;
      e.cyc  = a + 2 + i * (s + g);
      e.addr = AB'(32'(base) + i * 32'h1000);
      if (d == 0) sq_a.push_back(e); else sq_b.push_back(e);
    end
    exp_run[d] = a + 2 + (NC - 1) * (s + g) + s;
    @(negedge clock);
    go_a = 1'b0; go_b = 1'b0;
    check($sformatf("d%0d_hold_reset", d), (d == 0) ? bus_a.core_reset : bus_b.core_reset, 4'hf);
    check($sformatf("d%0d_hold_busy", d), (d == 0) ? busy_a : busy_b, 1);
    check($sformatf("d%0d_hold_count_cleared", d), (d == 0) ? count_a : count_b, 0);
  endtask

  task automatic wait_report_a(input int budget);
    int n = 0;
    while (!report_a && n < budget) begin @(negedge clock); n++; end
    check("wait_report", report_a, 1);
  endtask

  task automatic wait_done(input int d, input int budget);
    int n = 0;
    while (!((d == 0) ? boot_done_a : boot_done_b) && n < budget) begin
      @(negedge clock); n++;
    end
    check($sformatf("d%0d_wait_done", d), (d == 0) ? boot_done_a : boot_done_b, 1);
  endtask

  task automatic check_reset_values_a(input string tag);
    check({tag, "_core_reset"}, bus_a.core_reset, 4'hf);
    check({tag, "_core_start"}, bus_a.core_start, 0);
    check({tag, "_addr"}, bus_a.core_prog_address, 0);
    check({tag, "_report"}, report_a, 0);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_boot_done"}, boot_done_a, 0);
    check({tag, "_count"}, count_a, 0);
    check({tag, "_timeout"}, timeout_a, 0);
  endtask

  initial begin
    int n;
    bus_a.core_done = '0;
    bus_b.core_done = 4'hf;
    #3 reset = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_values_a("por");
    reset = 1'b1;

    // Back-to-back 3-cycle pulses; done already high so RUN lasts one cycle.
    boot(1, 20'h0abcd);
    dq_b.push_back('{count: 1, to: 1'b0});
    wait_done(1, 40);

    // Default stagger, done pulses 10 cycles apart, go during RUN ignored.
    boot(0, 20'h00000);
    n = 0;
    while (!bus_a.core_start[1] && n < 20) begin @(negedge clock); n++; end
    check("a_start1_seen", bus_a.core_start[1], 1);
    bus_a.core_done = 4'hf;
    @(negedge clock);
    bus_a.core_done = '0;
    wait_report_a(30);
    dq_a.push_back('{count: 21, to: 1'b0});
    for (int k = 0; k <= 20; k++) begin
      bus_a.core_done = (k == 0) ? 4'b0001 : (k == 10) ? 4'b0100 : (k == 20) ? 4'b1010 : 4'b0000;
      go_a = (k == 5);
      if (k == 15) check("a_partial_mask_still_running", {boot_done_a, report_a}, 2'b01);
      @(negedge clock);
    end
    bus_a.core_done = '0;
    go_a = 1'b0;
    wait_done(0, 5);
    check("a_done_core_reset", bus_a.core_reset, 0);

    // Wrapped addresses, then a one-cycle reset in the middle of START.
    boot(0, 20'hff000);
    n = 0;
    while (!bus_a.core_start[1] && n < 20) begin @(negedge clock); n++; end
    check("a_wrap_start1_seen", bus_a.core_start[1], 1);
    #2 reset = 1'b0;
    #1 check_reset_values_a("mid_reset");
    sq_a.delete();
    @(negedge clock);
    reset = 1'b1;

    // Clean restart, then leave the cores silent to exercise the watchdog.
    boot(0, 20'h12345);
    wait_report_a(30);
`ifdef BOOT_TIMEOUT_EN
    dq_a.push_back('{count: TO, to: 1'b1});
    wait_done(0, TO + 20);
`else
    repeat (60) @(negedge clock);
    check("a_no_watchdog_state", {boot_done_a, report_a, timeout_a}, 3'b010);
    check("a_no_watchdog_count", count_a, 60);
    dq_a.push_back('{count: 61, to: 1'b0});
    bus_a.core_done = 4'hf;
    @(negedge clock);
    bus_a.core_done = '0;
    wait_done(0, 5);
`endif
    repeat (2) @(negedge clock);
    check("a_start_queue_drained", sq_a.size(), 0);
    check("a_done_queue_drained", dq_a.size(), 0);
    check("b_start_queue_drained", sq_b.size(), 0);
    check("b_done_queue_drained", dq_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global time limit");
  end

endmodule
